// File: rtl/rdma_wr_demux.sv
// rdma_wr_demux: routes RDMA write commands and their payload stream from one
// network port to one of N_CHAN user channels, selected by the command PID.
// Commands are queued in an in-order route FIFO. Payload framing follows that
// order. Commands with an unroutable PID are consumed and their payload is
// discarded.
//
// Optional feature: define RDMA_DEMUX_LEN_CHECK_EN to enable the payload byte
// counter. It compares received bytes against the command length and counts
// mismatches in len_err_cnt. When the macro is undefined, len_err_cnt is tied
// to 0.
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   s_req_*                       command in (valid/ready/req_t)
//   s_axis_*                      payload in (tdata/tkeep/tid/tlast/tvalid/tready)
//   m_req_valid/ready[N_CHAN]     per-channel command handshake, shared m_req_data
//   m_axis_tvalid/tready[N_CHAN]  per-channel payload handshake, shared data/keep/id/last
//   drop_cnt                      saturating count of dropped commands
//   len_err_cnt                   saturating count of payload/length mismatches

package rdma_wr_demux_pkg;
  localparam int unsigned AXI_NET_BITS = 512;
  localparam int unsigned PID_BITS     = 6;
  localparam int unsigned VADDR_BITS   = 48;
  localparam int unsigned LEN_BITS     = 32;

  typedef struct packed {
    logic [PID_BITS-1:0]   pid;
    logic [VADDR_BITS-1:0] vaddr;
    logic [LEN_BITS-1:0]   len;
  } req_t;
endpackage

module rdma_wr_demux
  import rdma_wr_demux_pkg::*;
#(
  parameter int unsigned N_CHAN    = 2,
  parameter int unsigned REQ_DEPTH = 16,
  parameter int unsigned DATA_BITS = AXI_NET_BITS
) (
  input  logic                   aclk,
  input  logic                   areset,

  input  logic                   s_req_valid,
  output logic                   s_req_ready,
  input  req_t                   s_req_data,

  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic [PID_BITS-1:0]    s_axis_tid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,

  output logic [N_CHAN-1:0]      m_req_valid,
  input  logic [N_CHAN-1:0]      m_req_ready,
  output req_t                   m_req_data,

  output logic [N_CHAN-1:0]      m_axis_tvalid,
  input  logic [N_CHAN-1:0]      m_axis_tready,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic [PID_BITS-1:0]    m_axis_tid,
  output logic                   m_axis_tlast,

  output logic [31:0]            drop_cnt,
  output logic [31:0]            len_err_cnt
);

  localparam int unsigned CH_W   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int unsigned PTR_W  = $clog2(REQ_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic                drop;
`ifdef RDMA_DEMUX_LEN_CHECK_EN
    logic [LEN_BITS-1:0] len;
`endif
  } route_t;

  route_t             mem [REQ_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_full;
  logic               fifo_empty;

  logic               req_drop;
  logic [CH_W-1:0]    req_ch;
  logic               push;
  logic               pop;
  logic               beat_hs;
  route_t             head;
  route_t             entry;

  assign fifo_full  = (fifo_cnt == CNT_W'(REQ_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  // Any PID outside the channel range is unroutable.
  assign req_drop = (32'(s_req_data.pid) >= N_CHAN);
  assign req_ch   = CH_W'(s_req_data.pid);

  // Command path: combinational decode to the selected channel.
  always_comb begin
    s_req_ready = 1'b0;
    m_req_valid = '0;
    if (!areset && !fifo_full) begin
      if (req_drop) begin
        s_req_ready = 1'b1;
      end else begin
        s_req_ready         = m_req_ready[req_ch];
        m_req_valid[req_ch] = s_req_valid;
      end
    end
  end

  assign m_req_data = s_req_data;
  assign push       = s_req_valid && s_req_ready;

  always_comb begin
    entry      = '0;
    entry.ch   = req_ch;
    entry.drop = req_drop;
`ifdef RDMA_DEMUX_LEN_CHECK_EN
    entry.len  = s_req_data.len;
`endif
  end

  assign head = mem[rd_ptr];

  // Payload path: steered by the route FIFO head; stalls while empty.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = '0;
    if (!areset && !fifo_empty) begin
      if (head.drop) begin
        s_axis_tready = 1'b1;
      end else begin
        s_axis_tready          = m_axis_tready[head.ch];
        m_axis_tvalid[head.ch] = s_axis_tvalid;
      end
    end
  end

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tid   = s_axis_tid;
  assign m_axis_tlast = s_axis_tlast;

  assign beat_hs = s_axis_tvalid && s_axis_tready;
  assign pop     = beat_hs && s_axis_tlast;

  // Route FIFO storage; write enable is already gated by reset via s_req_ready.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Route FIFO pointers/occupancy and drop counter.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
      if (push && req_drop && (drop_cnt != 32'hFFFF_FFFF)) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

`ifdef RDMA_DEMUX_LEN_CHECK_EN
  localparam int unsigned KEEP_W = DATA_BITS / 8;
  localparam int unsigned BEAT_W = $clog2(KEEP_W + 1);

  logic [BEAT_W-1:0] beat_bytes;
  logic [31:0]       byte_cnt;
  logic [32:0]       byte_sum;
  logic [31:0]       byte_total;

  // Popcount of tkeep for the current beat.
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + BEAT_W'(s_axis_tkeep[i]);
    end
  end

  // Running total including this beat, saturating at 32 bits.
  assign byte_sum   = 33'(byte_cnt) + 33'(beat_bytes);
  assign byte_total = byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];

  // Byte accumulation and length check; applies to dropped packets as well.
  always_ff @(posedge aclk) begin
    if (areset) begin
      byte_cnt    <= '0;
      len_err_cnt <= '0;
    end else if (beat_hs) begin
      if (s_axis_tlast) begin
        byte_cnt <= '0;
        if ((byte_total != head.len) && (len_err_cnt != 32'hFFFF_FFFF)) begin
          len_err_cnt <= len_err_cnt + 32'd1;
        end
      end else begin
        byte_cnt <= byte_total;
      end
    end
  end
`else
  assign len_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rdma_wr_demux.sv
// tb_rdma_wr_demux: scoreboard bench for rdma_wr_demux. Stimulus pushes the
// expected command and payload handshakes into queues; a negedge monitor pops
// and compares them whenever a channel handshake is visible. Directed checks
// cover reset values, stalls, drops, FIFO-full blocking and the length check.
module tb_rdma_wr_demux;
  import rdma_wr_demux_pkg::*;

  localparam int unsigned N_CHAN    = 2;
  localparam int unsigned REQ_DEPTH = 16;
  localparam int unsigned DATA_BITS = 512;
  localparam int unsigned KEEP_W    = DATA_BITS / 8;
`ifdef RDMA_DEMUX_LEN_CHECK_EN
  localparam int unsigned EXP_LEN_ERR = 1;
`else
  localparam int unsigned EXP_LEN_ERR = 0;
`endif

  logic                 aclk;
  logic                 areset;
  logic                 s_req_valid;
  logic                 s_req_ready;
  req_t                 s_req_data;
  logic [DATA_BITS-1:0] s_axis_tdata;
  logic [KEEP_W-1:0]    s_axis_tkeep;
  logic [PID_BITS-1:0]  s_axis_tid;
  logic                 s_axis_tlast;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [N_CHAN-1:0]    m_req_valid;
  logic [N_CHAN-1:0]    m_req_ready;
  req_t                 m_req_data;
  logic [N_CHAN-1:0]    m_axis_tvalid;
  logic [N_CHAN-1:0]    m_axis_tready;
  logic [DATA_BITS-1:0] m_axis_tdata;
  logic [KEEP_W-1:0]    m_axis_tkeep;
  logic [PID_BITS-1:0]  m_axis_tid;
  logic                 m_axis_tlast;
  logic [31:0]          drop_cnt;
  logic [31:0]          len_err_cnt;

  rdma_wr_demux #(
    .N_CHAN   (N_CHAN),
    .REQ_DEPTH(REQ_DEPTH),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_req_valid  (s_req_valid),
    .s_req_ready  (s_req_ready),
    .s_req_data   (s_req_data),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tid   (s_axis_tid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_data   (m_req_data),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tid   (m_axis_tid),
    .m_axis_tlast (m_axis_tlast),
    .drop_cnt     (drop_cnt),
    .len_err_cnt  (len_err_cnt)
  );

  typedef struct {
    int unsigned          ch;
    logic [DATA_BITS-1:0] data;
    logic                 last;
  } beat_exp_t;

  typedef struct {
    int unsigned ch;
    req_t        req;
  } cmd_exp_t;

  beat_exp_t   beat_q[$];
  cmd_exp_t    cmd_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic req_t mk_req(input int unsigned pid, input int unsigned len);
    req_t r;
    r.pid   = PID_BITS'(pid);
    r.vaddr = VADDR_BITS'(64'h0001_0000 * 64'(pid) + 64'(len));
    r.len   = LEN_BITS'(len);
    return r;
  endfunction

  function automatic logic [DATA_BITS-1:0] beat_data(input int unsigned idx);
    logic [DATA_BITS-1:0] d;
    for (int i = 0; i < DATA_BITS / 32; i++) d[32*i +: 32] = 32'hA000_0000 + 32'(idx * 16 + i);
    return d;
  endfunction

  // Monitor: compare every visible output handshake against the queues.
  always @(negedge aclk) begin
    for (int c = 0; c < N_CHAN; c++) begin
      if (m_axis_tvalid[c] && m_axis_tready[c]) begin
        if (beat_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got beat on ch %0d expected none", c);
        end else begin
          beat_exp_t e;
          e = beat_q.pop_front();
          chk("beat_ch", 64'(c), 64'(e.ch));
          chk("beat_data_lo", m_axis_tdata[63:0], e.data[63:0]);
          chk("beat_data_hi", m_axis_tdata[DATA_BITS-1 -: 64], e.data[DATA_BITS-1 -: 64]);
          chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
        end
      end
      if (m_req_valid[c] && m_req_ready[c]) begin
        if (cmd_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_cmd: got cmd on ch %0d expected none", c);
        end else begin
          cmd_exp_t e;
          e = cmd_q.pop_front();
          chk("cmd_ch", 64'(c), 64'(e.ch));
          chk("cmd_pid", 64'(m_req_data.pid), 64'(e.req.pid));
          chk("cmd_len", 64'(m_req_data.len), 64'(e.req.len));
        end
      end
    end
  end

  // Wait for a handshake on the request (is_req=1) or payload input, bounded.
  task automatic wait_hs(input bit is_req);
    bit hs;
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      hs = is_req ? s_req_ready : s_axis_tready;
      @(posedge aclk);
      #1;
      n++;
    end while (!hs && n < 200);
    if (!hs) begin
      n_total++;
      $display("FAIL hs_timeout: got no handshake (is_req=%0d) expected one within 200 cycles", is_req);
    end
  endtask

  task automatic send_req(input int unsigned pid, input int unsigned len, input bit routed);
    s_req_data  = mk_req(pid, len);
    s_req_valid = 1'b1;
    if (routed) cmd_q.push_back('{ch: pid, req: mk_req(pid, len)});
    wait_hs(1'b1);
    s_req_valid = 1'b0;
  endtask

  task automatic set_beat(input int unsigned idx, input bit last);
    s_axis_tdata  = beat_data(idx);
    s_axis_tkeep  = '1;
    s_axis_tid    = PID_BITS'(idx);
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic send_beat(input int unsigned ch, input int unsigned idx, input bit last);
    set_beat(idx, last);
    beat_q.push_back('{ch: ch, data: beat_data(idx), last: last});
    wait_hs(1'b0);
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    areset        = 1'b1;
    s_req_valid   = 1'b0;
    s_req_data    = mk_req(0, 64);
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tid    = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_req_ready   = '1;
    m_axis_tready = '1;

    // Reset state.
    repeat (3) @(posedge aclk);
    #1;
    s_req_valid = 1'b1;
    @(negedge aclk);
    chk("rst_s_req_ready", 64'(s_req_ready), 64'd0);
    chk("rst_m_req_valid", 64'(m_req_valid), 64'd0);
    chk("rst_s_axis_tready", 64'(s_axis_tready), 64'd0);
    @(posedge aclk);
    #1;
    s_req_valid = 1'b0;
    areset      = 1'b0;
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_len_err_cnt", 64'(len_err_cnt), 64'd0);

    // T1: pid 1 len 128, beat arriving with its command stalls one cycle.
    s_req_data  = mk_req(1, 128);
    s_req_valid = 1'b1;
    cmd_q.push_back('{ch: 1, req: mk_req(1, 128)});
    set_beat(0, 1'b0);
    beat_q.push_back('{ch: 1, data: beat_data(0), last: 1'b0});
    #1;
    chk("t1_m_req_valid", 64'(m_req_valid), 64'b10);
    @(negedge aclk);
    chk("t1_s_req_ready", 64'(s_req_ready), 64'd1);
    chk("t1_same_cycle_stall", 64'(s_axis_tready), 64'd0);
    @(posedge aclk);
    #1;
    s_req_valid = 1'b0;
    wait_hs(1'b0);
    s_axis_tvalid = 1'b0;
    send_beat(1, 1, 1'b1);
    s_axis_tvalid = 1'b1;
    #1;
    chk("t1_empty_tready", 64'(s_axis_tready), 64'd0);
    chk("t1_empty_tvalid", 64'(m_axis_tvalid), 64'd0);
    s_axis_tvalid = 1'b0;
    chk("t1_len_err", 64'(len_err_cnt), 64'd0);

    // T2: pids 0,1,0 with channel 1 stalled for 5 cycles.
    send_req(0, 64, 1'b1);
    send_req(1, 64, 1'b1);
    send_req(0, 64, 1'b1);
    m_axis_tready[1] = 1'b0;
    send_beat(0, 10, 1'b1);
    fork
      send_beat(1, 11, 1'b1);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge aclk);
          chk("t2_stall_tready", 64'(s_axis_tready), 64'd0);
        end
        @(posedge aclk);
        #1;
        m_axis_tready[1] = 1'b1;
      end
    join
    send_beat(0, 12, 1'b1);

    // T3: unroutable pid 5, 3 beats discarded.
    s_req_data  = mk_req(5, 192);
    s_req_valid = 1'b1;
    #1;
    chk("t3_m_req_valid", 64'(m_req_valid), 64'd0);
    @(negedge aclk);
    chk("t3_s_req_ready", 64'(s_req_ready), 64'd1);
    @(posedge aclk);
    #1;
    s_req_valid = 1'b0;
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
    for (int b = 0; b < 3; b++) begin
      set_beat(20 + b, b == 2);
      @(negedge aclk);
      chk("t3_drop_tready", 64'(s_axis_tready), 64'd1);
      chk("t3_drop_tvalid", 64'(m_axis_tvalid), 64'd0);
      @(posedge aclk);
      #1;
    end
    #1;
    chk("t3_after_tready", 64'(s_axis_tready), 64'd0);
    s_axis_tvalid = 1'b0;
    chk("t3_len_err", 64'(len_err_cnt), 64'd0);

    // T4: fill the route FIFO; a pop in the same cycle does not unblock push.
    for (int i = 0; i < REQ_DEPTH; i++) send_req(0, 64, 1'b1);
    s_req_data  = mk_req(0, 64);
    s_req_valid = 1'b1;
    #1;
    chk("t4_full_ready", 64'(s_req_ready), 64'd0);
    chk("t4_full_m_req_valid", 64'(m_req_valid), 64'd0);
    set_beat(100, 1'b1);
    beat_q.push_back('{ch: 0, data: beat_data(100), last: 1'b1});
    @(negedge aclk);
    chk("t4_pop_tready", 64'(s_axis_tready), 64'd1);
    chk("t4_pop_same_cycle_ready", 64'(s_req_ready), 64'd0);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    cmd_q.push_back('{ch: 0, req: mk_req(0, 64)});
    @(negedge aclk);
    chk("t4_next_cycle_ready", 64'(s_req_ready), 64'd1);
    @(posedge aclk);
    #1;
    s_req_valid = 1'b0;
    for (int i = 0; i < REQ_DEPTH; i++) send_beat(0, 101 + i, 1'b1);
    s_axis_tvalid = 1'b1;
    #1;
    chk("t4_drained_tready", 64'(s_axis_tready), 64'd0);
    s_axis_tvalid = 1'b0;
    chk("t4_len_err", 64'(len_err_cnt), 64'd0);

    // T5: len 100 against 128 received bytes.
    send_req(0, 100, 1'b1);
    send_beat(0, 200, 1'b0);
    send_beat(0, 201, 1'b1);
    chk("t5_len_err", 64'(len_err_cnt), 64'(EXP_LEN_ERR));

    // T6: reset after beat 1 of a 3-beat packet.
    send_req(0, 192, 1'b1);
    send_beat(0, 300, 1'b0);
    set_beat(301, 1'b0);
    s_req_data  = mk_req(0, 64);
    s_req_valid = 1'b1;
    areset      = 1'b1;
    @(negedge aclk);
    chk("t6_rst_s_req_ready", 64'(s_req_ready), 64'd0);
    chk("t6_rst_m_req_valid", 64'(m_req_valid), 64'd0);
    chk("t6_rst_s_axis_tready", 64'(s_axis_tready), 64'd0);
    chk("t6_rst_m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
    @(posedge aclk);
    #1;
    areset      = 1'b0;
    s_req_valid = 1'b0;
    chk("t6_drop_cnt_cleared", 64'(drop_cnt), 64'd0);
    chk("t6_len_err_cleared", 64'(len_err_cnt), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("t6_leftover_stall", 64'(s_axis_tready), 64'd0);
      chk("t6_leftover_tvalid", 64'(m_axis_tvalid), 64'd0);
      @(posedge aclk);
      #1;
    end
    beat_q.push_back('{ch: 1, data: beat_data(301), last: 1'b0});
    send_req(1, 128, 1'b1);
    wait_hs(1'b0);
    s_axis_tvalid = 1'b0;
    send_beat(1, 302, 1'b1);
    chk("t6_len_err", 64'(len_err_cnt), 64'd0);

    repeat (3) @(posedge aclk);
    #1;
    chk("beat_q_left", 64'(beat_q.size()), 64'd0);
    chk("cmd_q_left", 64'(cmd_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
